// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for an N-stage pipeline.
// Covers imem/dmem misses, load-use bubbles and branch redirects.
module pipeline_hazard_ctrl #(
    parameter int N_STAGES    = 6,
    parameter int LU_STAGE    = 3,
    parameter int REDIR_STAGE = 4,
    parameter int MEM_STAGE   = 5,
    parameter int LU_BUBBLES  = 1,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                imem_miss,
    input  logic                dmem_miss,
    input  logic                load_use_req,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic [N_STAGES-1:0] stall_o,
    output logic [N_STAGES-1:0] flush_o,
    output logic                redirect_take,
    output logic [ADDR_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    redirect_count
);

    generate
        if (!(0 < LU_STAGE && LU_STAGE < REDIR_STAGE &&
              REDIR_STAGE <= MEM_STAGE && MEM_STAGE < N_STAGES &&
              LU_BUBBLES >= 1)) begin : g_bad_params
            $error("pipeline_hazard_ctrl: illegal stage parameters");
        end
    endgenerate

    localparam int LU_W = (LU_BUBBLES > 1) ? $clog2(LU_BUBBLES) : 1;
    localparam logic [LU_W-1:0] LU_INIT = LU_W'(LU_BUBBLES - 1);
    localparam logic [LU_W-1:0] LU_ONE  = LU_W'(1);

    localparam logic [N_STAGES-1:0] ONE       = N_STAGES'(1);
    localparam logic [N_STAGES-1:0] MEM_MASK  = (ONE << (MEM_STAGE + 1)) - ONE;
    localparam logic [N_STAGES-1:0] LU_MASK   = (ONE << (LU_STAGE + 1)) - ONE;
    localparam logic [N_STAGES-1:0] LU_FLUSH  = ONE << (LU_STAGE + 1);
    localparam logic [N_STAGES-1:0] RD_FLUSH  = ((ONE << REDIR_STAGE) - ONE) & ~ONE;

    typedef enum logic [1:0] {
        RUN,
        LU_HOLD,
        REDIR_PEND
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LU_W-1:0]     r_lu_cnt;
    logic [LU_W-1:0]     w_lu_cnt;
    logic [ADDR_W-1:0]   r_pend_pc;
    logic [ADDR_W-1:0]   w_pend_pc;
    logic [N_STAGES-1:0] w_stall;
    logic [N_STAGES-1:0] w_flush;
    logic                w_take;
    logic [ADDR_W-1:0]   w_pc;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_redirect_count;

    // Priority hazard decode: dmem freeze, redirect, load-use, imem miss
    always_comb begin
        w_next    = r_state;
        w_lu_cnt  = r_lu_cnt;
        w_pend_pc = r_pend_pc;
        w_stall   = '0;
        w_flush   = '0;
        w_take    = 1'b0;
        w_pc      = '0;
        if (!reset_n) begin
            w_next = RUN;
        end else if (dmem_miss) begin
            w_stall = MEM_MASK;
        end else if (redirect_valid || r_state == REDIR_PEND) begin
            w_flush  = RD_FLUSH;
            w_lu_cnt = '0;
            if (!imem_miss) begin
                w_take = 1'b1;
                w_pc   = redirect_valid ? redirect_target : r_pend_pc;
                w_next = RUN;
            end else begin
                w_stall = ONE;
                if (redirect_valid) begin
                    w_pend_pc = redirect_target;
                end
                w_next = REDIR_PEND;
            end
        end else if (load_use_req || r_state == LU_HOLD) begin
            w_stall = LU_MASK;
            w_flush = LU_FLUSH;
            if (load_use_req) begin
                w_lu_cnt = LU_INIT;
                w_next   = (LU_BUBBLES > 1) ? LU_HOLD : RUN;
            end else begin
                w_lu_cnt = (r_lu_cnt != '0) ? r_lu_cnt - LU_ONE : '0;
                w_next   = (r_lu_cnt <= LU_ONE) ? RUN : LU_HOLD;
            end
        end else if (imem_miss) begin
            w_stall = ONE;
            w_flush = ONE << 1;
        end
        if (w_stall[1]) begin
            w_flush[1] = 1'b0;
        end
    end

    // FSM state, bubble count and pending redirect target
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RUN;
            r_lu_cnt  <= '0;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_next;
            r_lu_cnt  <= w_lu_cnt;
            r_pend_pc <= w_pend_pc;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            if (w_stall[0] && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_take && r_redirect_count != '1) begin
                r_redirect_count <= r_redirect_count + CNT_W'(1);
            end
        end
    end

    assign stall_o        = w_stall;
    assign flush_o        = w_flush;
    assign redirect_take  = w_take;
    assign redirect_pc    = w_pc;
    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// LU_BUBBLES=2 and a 4-bit counter width to reach saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_miss;
    logic        dmem_miss;
    logic        load_use_req;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [5:0]  stall_o;
    logic [5:0]  flush_o;
    logic        redirect_take;
    logic [31:0] redirect_pc;
    logic [3:0]  stall_cycles;
    logic [3:0]  redirect_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .N_STAGES   (6),
        .LU_STAGE   (3),
        .REDIR_STAGE(4),
        .MEM_STAGE  (5),
        .LU_BUBBLES (2),
        .ADDR_W     (32),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_miss      (imem_miss),
        .dmem_miss      (dmem_miss),
        .load_use_req   (load_use_req),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .redirect_take  (redirect_take),
        .redirect_pc    (redirect_pc),
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // apply inputs for one cycle, then let them settle before checking
    task automatic drive(input logic im, input logic dm, input logic lu,
                         input logic rv, input logic [31:0] tgt);
        cyc();
        imem_miss       = im;
        dmem_miss       = dm;
        load_use_req    = lu;
        redirect_valid  = rv;
        redirect_target = tgt;
        #3;
    endtask

    task automatic ctl(input string tag, input logic [5:0] st,
                       input logic [5:0] fl, input logic tk,
                       input logic [31:0] pc);
        check({tag, ".stall"}, 64'(stall_o), 64'(st));
        check({tag, ".flush"}, 64'(flush_o), 64'(fl));
        check({tag, ".take"}, 64'(redirect_take), 64'(tk));
        check({tag, ".pc"}, 64'(redirect_pc), 64'(pc));
    endtask

    initial begin
        reset_n         = 1'b0;
        imem_miss       = 1'b1;
        dmem_miss       = 1'b0;
        load_use_req    = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h99;
        cyc();
        cyc();
        ctl("in_reset", 6'b0, 6'b0, 1'b0, 32'h0);
        check("rst.stall_cycles", 64'(stall_cycles), 64'd0);
        check("rst.redirect_count", 64'(redirect_count), 64'd0);

        cyc();
        reset_n = 1'b1;
        imem_miss = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 32'h0);
            ctl("idle", 6'b0, 6'b0, 1'b0, 32'h0);
        end
        check("idle.stall_cycles", 64'(stall_cycles), 64'd0);
        check("idle.redirect_count", 64'(redirect_count), 64'd0);

        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 32'h0);
            ctl("imiss", 6'b000001, 6'b000010, 1'b0, 32'h0);
        end
        drive(0, 0, 0, 0, 32'h0);
        ctl("imiss_end", 6'b0, 6'b0, 1'b0, 32'h0);
        check("imiss.stall_cycles", 64'(stall_cycles), 64'd3);

        drive(1, 0, 0, 1, 32'h80);
        ctl("rd_new", 6'b000001, 6'b001110, 1'b0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        ctl("rd_pend", 6'b000001, 6'b001110, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        ctl("rd_take", 6'b0, 6'b001110, 1'b1, 32'h80);
        drive(0, 0, 0, 0, 32'h0);
        ctl("rd_after", 6'b0, 6'b0, 1'b0, 32'h0);
        check("rd.redirect_count", 64'(redirect_count), 64'd1);
        check("rd.stall_cycles", 64'(stall_cycles), 64'd5);

        drive(0, 0, 1, 0, 32'h0);
        ctl("lu_req", 6'b001111, 6'b010000, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        ctl("lu_hold", 6'b001111, 6'b010000, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        ctl("lu_run", 6'b0, 6'b0, 1'b0, 32'h0);
        check("lu.stall_cycles", 64'(stall_cycles), 64'd7);

        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 1, 32'h44);
            ctl("dmiss", 6'b111111, 6'b0, 1'b0, 32'h0);
        end
        drive(0, 0, 0, 1, 32'h44);
        ctl("dmiss_take", 6'b0, 6'b001110, 1'b1, 32'h44);
        drive(0, 0, 0, 0, 32'h0);
        check("dmiss.stall_cycles", 64'(stall_cycles), 64'd11);
        check("dmiss.redirect_count", 64'(redirect_count), 64'd2);

        drive(0, 0, 1, 1, 32'h100);
        ctl("lu_vs_rd", 6'b0, 6'b001110, 1'b1, 32'h100);
        drive(0, 0, 0, 0, 32'h0);
        ctl("lu_vs_rd_run", 6'b0, 6'b0, 1'b0, 32'h0);
        check("lu_vs_rd.redirect_count", 64'(redirect_count), 64'd3);

        drive(1, 0, 1, 0, 32'h0);
        ctl("lu_imiss", 6'b001111, 6'b010000, 1'b0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        ctl("lu_imiss_hold", 6'b001111, 6'b010000, 1'b0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        ctl("lu_imiss_run", 6'b000001, 6'b000010, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        check("lu_imiss.stall_cycles", 64'(stall_cycles), 64'd14);

        drive(1, 0, 0, 1, 32'h10);
        ctl("ow_a", 6'b000001, 6'b001110, 1'b0, 32'h0);
        drive(1, 0, 0, 1, 32'h20);
        ctl("ow_b", 6'b000001, 6'b001110, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        ctl("ow_take", 6'b0, 6'b001110, 1'b1, 32'h20);
        drive(1, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        check("sat.stall_cycles", 64'(stall_cycles), 64'hf);
        check("sat.redirect_count", 64'(redirect_count), 64'd4);

        drive(0, 0, 1, 0, 32'h0);
        ctl("rst_lu_req", 6'b001111, 6'b010000, 1'b0, 32'h0);
        cyc();
        load_use_req = 1'b0;
        reset_n = 1'b0;
        #3;
        ctl("rst_lu_in", 6'b0, 6'b0, 1'b0, 32'h0);
        cyc();
        reset_n = 1'b1;
        #3;
        ctl("rst_lu_run", 6'b0, 6'b0, 1'b0, 32'h0);
        check("rst_lu.stall_cycles", 64'(stall_cycles), 64'd0);

        drive(1, 0, 0, 1, 32'h55);
        ctl("rst_rd_pend", 6'b000001, 6'b001110, 1'b0, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        imem_miss = 1'b0;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #3;
        ctl("rst_rd_run", 6'b0, 6'b0, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        ctl("rst_rd_idle", 6'b0, 6'b0, 1'b0, 32'h0);
        check("rst_rd.redirect_count", 64'(redirect_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
